// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for the 4-bit MIPS logic unit.
// It accepts one request, executes it in one registered step, and returns a tagged result pulse.
`timescale 1ns/1ps

module logic_unit_lane (
   input  logic       a,
   input  logic       b,
   input  logic [1:0] f,
   output logic       y
);
   always_comb begin
      case (f)
         2'd0:    y = a & b;
         2'd1:    y = a | b;
         2'd2:    y = a ^ b;
         default: y = ~(a | b);
      endcase
   end
endmodule

module logic_unit_arbiter #(
   parameter  int N = 2,
   localparam int W = 1 << N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [1:0]   f0,
   input  logic         req1,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   input  logic [1:0]   f1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         busy,
   output logic [W-1:0] y,
   output logic         y_valid,
   output logic         y_owner,
   output logic [7:0]   op_count
);
   typedef enum logic {IDLE, EXEC} state_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   f;
   } op_t;

   state_t       state;
   op_t          op_q;
   op_t          op_sel;
   logic         win;
   logic         owner;
   logic         last_owner;
   logic [W-1:0] res;

   // On contention the requester that did not win last time goes first.
   assign win = (req0 && req1) ? ~last_owner : req1;

   always_comb begin
      op_sel = win ? op_t'{a: a1, b: b1, f: f1} : op_t'{a: a0, b: b0, f: f0};
   end

   for (genvar i = 0; i < W; i++) begin : g_lane
      logic_unit_lane u_lane (
         .a (op_q.a[i]),
         .b (op_q.b[i]),
         .f (op_q.f),
         .y (res[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         op_q       <= '0;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         busy       <= 1'b0;
         y          <= '0;
         y_valid    <= 1'b0;
         y_owner    <= 1'b0;
         op_count   <= 8'd0;
      end else begin
         y_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  op_q       <= op_sel;
                  owner      <= win;
                  last_owner <= win;
                  gnt0       <= ~win;
                  gnt1       <= win;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               y        <= res;
               y_owner  <= owner;
               y_valid  <= 1'b1;
               op_count <= op_count + 8'd1;
               gnt0     <= 1'b0;
               gnt1     <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: stimulus queues expected results,
// a negedge monitor checks every y_valid pulse and the grant invariants.
`timescale 1ns/1ps

module tb_logic_unit_arbiter;
   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic [1:0] f0, f1;
   logic       gnt0, gnt1, busy, y_valid, y_owner;
   logic [3:0] y;
   logic [7:0] op_count;

   typedef struct {
      logic [3:0] y;
      logic       owner;
      logic [7:0] cnt;
      int         gap;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   last_vld = 0;

   logic_unit_arbiter #(.N(2)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .a0(a0), .b0(b0), .f0(f0),
      .req1(req1), .a1(a1), .b1(b1), .f1(f1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
      .y(y), .y_valid(y_valid), .y_owner(y_owner), .op_count(op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [3:0] lu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
      case (f)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a | b);
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Returns in the grant cycle (at a negedge) so the caller can drop req before the next edge.
   task automatic wait_gnt(input int idx);
      bit seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         seen = (idx == 0) ? gnt0 : gnt1;
      end
      if (!seen) chk($sformatf("gnt%0d_timeout", idx), 32'd0, 32'd1);
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (gnt0 || gnt1 || y_valid)
            chk("gnt_exclusive", {30'd0, gnt0 & gnt1, y_valid & (gnt0 | gnt1)}, 32'd0);
         if (y_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_y_valid", {31'd0, y_valid}, 32'd0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("y", {28'd0, y}, {28'd0, e.y});
               chk("y_owner", {31'd0, y_owner}, {31'd0, e.owner});
               chk("op_count", {24'd0, op_count}, {24'd0, e.cnt});
               if (e.gap != 0) chk("y_valid_gap", cyc - last_vld, e.gap);
            end
            last_vld = cyc;
         end
      end
   end

   initial begin
      reset = 1'b1;
      req0 = 1'b1; a0 = 4'hC; b0 = 4'hA; f0 = 2'd1;
      req1 = 1'b1; a1 = 4'hC; b1 = 4'hA; f1 = 2'd2;

      // Reset held with both requests high: everything stays zero.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_outputs", {15'd0, gnt0, gnt1, busy, y, y_valid, y_owner, op_count}, 32'd0);
      end

      // Contention straight out of reset: requester 0 first (OR), then 1 (XOR).
      q.push_back(exp_t'{4'hE, 1'b0, 8'd1, 0});
      q.push_back(exp_t'{4'h6, 1'b1, 8'd2, 2});
      @(posedge clk); #1 reset = 1'b0;
      wait_gnt(0);
      req0 = 1'b0;
      wait_gnt(1);
      req1 = 1'b0;
      repeat (3) @(negedge clk);

      // Single AND request.
      q.push_back(exp_t'{4'h8, 1'b0, 8'd3, 0});
      a0 = 4'hC; b0 = 4'hA; f0 = 2'd0; req0 = 1'b1;
      wait_gnt(0);
      req0 = 1'b0;
      repeat (3) @(negedge clk);

      // NOR with operand A changed during the grant cycle: latched value must be used.
      q.push_back(exp_t'{4'h1, 1'b0, 8'd4, 0});
      a0 = 4'hC; b0 = 4'hA; f0 = 2'd3; req0 = 1'b1;
      wait_gnt(0);
      a0 = 4'h0; req0 = 1'b0;
      repeat (3) @(negedge clk);

      // Reset pulsed during the grant cycle discards the operation.
      a1 = 4'h3; b1 = 4'h5; f1 = 2'd1; req1 = 1'b1;
      wait_gnt(1);
      req1 = 1'b0;
      reset = 1'b1;
      #1 chk("reset_mid_exec", {15'd0, gnt0, gnt1, busy, y, y_valid, y_owner, op_count}, 32'd0);
      #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("post_reset_state", {19'd0, busy, y, op_count}, 32'd0);

      // 256 back-to-back operations on requester 1 with req held high: count wraps to 0.
      for (int k = 0; k < 256; k++) begin
         logic [7:0] kb;
         kb = 8'(k);
         a1 = kb[5:2]; b1 = ~kb[3:0]; f1 = kb[1:0];
         q.push_back(exp_t'{lu(kb[5:2], ~kb[3:0], kb[1:0]), 1'b1, 8'(k + 1), (k == 0) ? 0 : 2});
         req1 = 1'b1;
         wait_gnt(1);
      end
      req1 = 1'b0;

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      chk("scoreboard_drained", q.size(), 32'd0);
      repeat (3) @(negedge clk);
      chk("wrap_op_count", {24'd0, op_count}, 32'd0);
      chk("idle_after_wrap", {30'd0, busy, gnt1}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
